// File: rtl/hu_io_pkg.sv
// Shared I/O map constants and decode helper for the HuC6280 timer block.
package hu_io_pkg;

  localparam logic [20:0] TIMER_BASE   = 21'h1FEC00;
  localparam logic [20:0] TIMER_END    = 21'h1FEFFF;
  localparam logic [20:0] IRQ_ACK_ADDR = 21'h1FF403;

  // Position of the timer request in the IRQ status byte.
  localparam int TIMER_IRQ_BIT = 2;

  // Down-counter / reload width.
  localparam int CNT_W = 7;

  // Which timer-visible register a bus address selects.
  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_CNT  = 2'd1,
    PORT_CTL  = 2'd2,
    PORT_ACK  = 2'd3
  } tmr_port_e;

  // The two timer registers are mirrored across the whole window on addr[0].
  function automatic tmr_port_e tmr_decode(input logic [20:0] a);
    tmr_port_e p;
    p = PORT_NONE;
    if (a >= TIMER_BASE && a <= TIMER_END)
      p = a[0] ? PORT_CTL : PORT_CNT;
    else if (a == IRQ_ACK_ADDR)
      p = PORT_ACK;
    return p;
  endfunction

endpackage

// File: rtl/hu_timer_prescaler.sv
// Free-running clock divider for the interval timer; emits one tick per PRESCALE cycles.
module hu_timer_prescaler #(
  parameter int PRESCALE = 1024,
  parameter int PS_W     = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  logic [PS_W-1:0] ps;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  // Tick on the last count of each prescale period, only while enabled.
  assign tick = en && (ps == PS_LAST);

  // Count 0..PRESCALE-1 while enabled; held at zero when stopped or cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ps <= '0;
    else if (clear || !en)
      ps <= '0;
    else if (ps == PS_LAST)
      ps <= '0;
    else
      ps <= ps + PS_W'(1);
  end

endmodule

// File: rtl/hu_timer.sv
// HuC6280 interval timer: 7-bit prescaled down-counter with level IRQ and bus read port.
module hu_timer
  import hu_io_pkg::*;
#(
  parameter int PRESCALE = 1024,
  parameter int PS_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [20:0] addr,
  input  logic [7:0]  dIn,
  input  logic        re,
  input  logic        we,
  output logic [7:0]  dOut,
  output logic        hit,
  output logic        irq_timer,
  output logic        running
);

  tmr_port_e       port;
  logic            wr, rd;
  logic            wr_cnt, wr_ctl, wr_ack;
  logic            start, stop;
  logic            tick, tick_eff, underflow;
  logic [CNT_W-1:0] counter, reload, reload_nxt;
  logic [7:0]      rdata;
  logic            unused_din;

  // Top data bit has no register behind it.
  assign unused_din = dIn[7];

  assign port = tmr_decode(addr);

  // A cycle with both strobes high is treated as a bus error and ignored.
  assign wr = we && !re;
  assign rd = re && !we;

  assign wr_cnt = wr && (port == PORT_CNT);
  assign wr_ctl = wr && (port == PORT_CTL);
  assign wr_ack = wr && (port == PORT_ACK);

  // Only real enable transitions restart the prescaler; a redundant start is a no-op.
  assign start = wr_ctl &&  dIn[0] && !running;
  assign stop  = wr_ctl && !dIn[0] &&  running;

  // A stop landing on a tick cycle swallows that tick.
  assign tick_eff  = tick && !stop;
  assign underflow = tick_eff && (counter == '0);

  // An underflow coinciding with a reload write picks up the new value.
  assign reload_nxt = wr_cnt ? dIn[CNT_W-1:0] : reload;

  hu_timer_prescaler #(
    .PRESCALE (PRESCALE),
    .PS_W     (PS_W)
  ) u_ps (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start || stop),
    .en    (running),
    .tick  (tick)
  );

  // Reload latch and enable bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reload  <= '0;
      running <= 1'b0;
    end else begin
      reload <= reload_nxt;
      if (wr_ctl)
        running <= dIn[0];
    end
  end

  // Down-counter: load on start, decrement per tick, reload on underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      counter <= '0;
    else if (start)
      counter <= reload;
    else if (tick_eff)
      counter <= (counter == '0) ? reload_nxt : counter - CNT_W'(1);
  end

  // Level IRQ: set on underflow (wins over ack), cleared by ack write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq_timer <= 1'b0;
    else if (underflow)
      irq_timer <= 1'b1;
    else if (wr_ack)
      irq_timer <= 1'b0;
  end

  // Read-data select for the addressed register.
  always_comb begin
    rdata = '0;
    case (port)
      PORT_CNT: rdata = {1'b0, counter};
      PORT_CTL: rdata = {7'b0, running};
      PORT_ACK: rdata[TIMER_IRQ_BIT] = irq_timer;
      default:  rdata = '0;
    endcase
  end

  // One-cycle registered read response; zero when not addressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dOut <= '0;
      hit  <= 1'b0;
    end else if (rd && port != PORT_NONE) begin
      dOut <= rdata;
      hit  <= 1'b1;
    end else begin
      dOut <= '0;
      hit  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hu_timer.sv
// Directed bench for hu_timer at PRESCALE=4.
module tb_hu_timer;

  localparam logic [20:0] A_CNT = 21'h1FEC00;
  localparam logic [20:0] A_CTL = 21'h1FEC01;
  localparam logic [20:0] A_ACK = 21'h1FF403;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [20:0] addr = '0;
  logic [7:0]  dIn = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  dOut;
  logic        hit;
  logic        irq_timer;
  logic        running;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;

  logic [7:0] d;
  logic       h;
  logic [7:0] cnt_seq [1:13];
  logic       irq_seq [1:13];

  hu_timer #(.PRESCALE(4), .PS_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .dIn       (dIn),
    .re        (re),
    .we        (we),
    .dOut      (dOut),
    .hit       (hit),
    .irq_timer (irq_timer),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic wait_until(input int k);
    while (t < k) step();
  endtask

  task automatic bus_wr(input logic [20:0] a, input logic [7:0] v);
    addr = a; dIn = v; we = 1'b1;
    @(negedge clk);
    t++;
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [20:0] a, output logic [7:0] rv, output logic rh);
    addr = a; re = 1'b1;
    @(negedge clk);
    t++;
    rv = dOut; rh = hit;
    re = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset mid-count with IRQ pending and a read response in flight
    bus_wr(A_CNT, 8'h00);
    bus_wr(A_CTL, 8'h01);
    repeat (6) step();
    chk("pre_reset_irq", irq_timer, 1);
    bus_rd(A_CTL, d, h);
    chk("pre_reset_hit", h, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_irq", irq_timer, 0);
    chk("rst_running", running, 0);
    chk("rst_hit", hit, 0);
    chk("rst_dout", dOut, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_rd(A_CNT, d, h);
    chk("rst_cnt_rd", d, 8'h00);
    chk("rst_cnt_hit", h, 1);

    // Basic period, reload=2: IRQ 12 cycles after the start edge
    bus_wr(A_CNT, 8'h02);
    bus_wr(A_CTL, 8'h01);
    t = 0;
    for (int k = 1; k <= 13; k++) begin
      bus_rd(A_CNT, d, h);
      cnt_seq[k] = d;
      irq_seq[k] = irq_timer;
    end
    chk("per_cnt_k1", cnt_seq[1], 2);
    chk("per_cnt_k5", cnt_seq[5], 1);
    chk("per_cnt_k9", cnt_seq[9], 0);
    chk("per_cnt_k13", cnt_seq[13], 2);
    chk("per_irq_k11", irq_seq[11], 0);
    chk("per_irq_k12", irq_seq[12], 1);

    // Ack, then second period, then ack on the underflow edge
    bus_wr(A_ACK, 8'hFF);
    chk("ack_clear", irq_timer, 0);
    wait_until(23);
    chk("per2_before", irq_timer, 0);
    step();
    chk("per2_at", irq_timer, 1);
    bus_wr(A_ACK, 8'hFF);
    chk("ack2_clear", irq_timer, 0);
    wait_until(35);
    bus_wr(A_ACK, 8'hFF);
    chk("ack_vs_underflow", irq_timer, 1);

    // Stop/hold with reload=5
    bus_wr(A_CTL, 8'h00);
    bus_wr(A_ACK, 8'h00);
    bus_wr(A_CNT, 8'h05);
    bus_wr(A_CTL, 8'h01);
    t = 0;
    wait_until(8);
    bus_wr(A_CTL, 8'h00);
    bus_rd(A_CNT, d, h);
    chk("hold_cnt", d, 3);
    repeat (30) step();
    chk("hold_no_irq", irq_timer, 0);
    bus_rd(A_CNT, d, h);
    chk("hold_cnt_later", d, 3);
    bus_wr(A_CTL, 8'h01);
    bus_rd(A_CNT, d, h);
    chk("restart_cnt", d, 5);

    // Stop coinciding with an underflow tick discards it
    bus_wr(A_CTL, 8'h00);
    bus_wr(A_CNT, 8'h00);
    bus_wr(A_CTL, 8'h01);
    t = 0;
    wait_until(3);
    bus_wr(A_CTL, 8'h00);
    chk("stop_on_tick_irq", irq_timer, 0);
    chk("stop_on_tick_run", running, 0);

    // Reload change while running: current run finishes from 3
    bus_wr(A_CNT, 8'h03);
    bus_wr(A_CTL, 8'h01);
    t = 0;
    bus_wr(A_CNT, 8'h01);
    wait_until(15);
    chk("rl_before", irq_timer, 0);
    step();
    chk("rl_at16", irq_timer, 1);
    bus_wr(A_ACK, 8'h00);
    wait_until(23);
    chk("rl_before24", irq_timer, 0);
    bus_wr(A_CNT, 8'h02);
    chk("rl_at24", irq_timer, 1);
    bus_rd(A_CNT, d, h);
    chk("rl_new_on_uf", d, 2);

    // IRQ held while stopped; illegal access; mirrors; unselected
    bus_wr(A_CTL, 8'h00);
    step();
    chk("irq_held_stopped", irq_timer, 1);
    addr = A_CNT; dIn = 8'h55; re = 1'b1; we = 1'b1;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    chk("ill_hit", hit, 0);
    chk("ill_dout", dOut, 0);
    bus_wr(A_CTL, 8'h01);
    bus_rd(21'h1FEDF0, d, h);
    chk("mirror_cnt", d, 2);
    chk("mirror_hit", h, 1);
    bus_rd(21'h1FEFFF, d, h);
    chk("mirror_ctl", d, 1);
    bus_rd(A_ACK, d, h);
    chk("ack_rd", d, 8'h04);
    bus_rd(21'h1FF000, d, h);
    chk("unsel_hit", h, 0);
    chk("unsel_dout", d, 0);
    bus_rd(21'h1FEBFF, d, h);
    chk("below_hit", h, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hu_timer.md
Name: hu_timer

Overview:
- HuC6280 on-chip interval timer. It sits on the 21-bit physical bus beside the memory/IO decoder and consumes the same addr/dIn/re/we strobes.
- Decodes the TIMER window 0x1FEC00-0x1FEFFF and the IRQ-acknowledge address 0x1FF403.
- Maintains a 7-bit down-counter driven by a clock prescaler, and raises a level timer IRQ on underflow.
- Provides registered read data to the bus read-data mux.

Parameters:
- PRESCALE, 1024: clk cycles per counter decrement.
- PS_W, 10: prescaler width; must equal clog2(PRESCALE).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  21  physical address.
- dIn  in  8  write data.
- re  in  1  read strobe.
- we  in  1  write strobe.
- dOut  out  8  read data, registered, valid the cycle after a hit read.
- hit  out  1  registered; 1 when dOut carries timer data this cycle.
- irq_timer  out  1  level interrupt request to the CPU interrupt controller.
- running  out  1  current enable state (debug/observability).

Behaviour:
- Reset: counter=0, reload=0, running=0, prescaler=0, irq_timer=0, dOut=0, hit=0. Reset is asynchronous and may assert mid-count; all state clears immediately.
- Decode: tsel = addr in [0x1FEC00, 0x1FEFFF]; the port is selected by addr[0] (mirrored across the window). asel = addr == 0x1FF403.
- re and we both high: no register effect, hit=0, dOut=0, internal err flag set (sim-only $display).
- Write port 0 (tsel, addr[0]=0): reload <= dIn[6:0]. The counter is not affected while running.
- Write port 1 (tsel, addr[0]=1): running <= dIn[0].
  - Rising 0->1: counter <= reload, prescaler <= 0 in that same cycle.
  - Falling 1->0: counter holds its value, prescaler <= 0.
- Read port 0: dOut <= {1'b0, counter} on the next posedge, hit=1 for one cycle.
- Read port 1: dOut <= {7'b0, running}, hit=1.
- Read asel: dOut <= {5'b0, irq_timer, 2'b0}, hit=1.
- Reads have no side effects. Latency is exactly 1 cycle, matching the memory model read timing.
- Write asel (any data): irq_timer <= 0.
- Tick: while running, prescaler counts 0..PRESCALE-1 and wraps. tick = running && prescaler == PRESCALE-1.
- On tick:
  - If counter != 0: counter <= counter-1 (7-bit, no wrap).
  - If counter == 0: counter <= reload and irq_timer <= 1.
- Period: (reload+1)*PRESCALE cycles per IRQ. reload=0 gives an IRQ every PRESCALE cycles.
- Simultaneous events:
  - Ack write and underflow in the same cycle: irq_timer ends 1 (set wins).
  - Reload write and underflow in the same cycle: counter loads the NEW reload value.
  - Start write (0->1) while already running: no reload, no prescaler clear.
  - Stop write coinciding with tick: the tick is discarded (stop wins), no IRQ.
- irq_timer stays asserted until acknowledged, including while stopped.
- Unselected addresses: hit=0, dOut=0, no state change.

Decomposition:
- Shared package hu_io_pkg holds:
  - address constants TIMER_BASE=21'h1FEC00, TIMER_END=21'h1FEFFF, IRQ_ACK_ADDR=21'h1FF403;
  - the IRQ status bit index (TIMER_IRQ_BIT=2);
  - the counter width localparam (7).
- One natural sub-module: hu_timer_prescaler.
  - Inputs: clk, rst_n, clear, en.
  - Output: tick.
  - Parameterised by PRESCALE.

Test Plan (PRESCALE=4 unless noted):
- Reset and readback: assert rst_n=0 mid-count -> all outputs 0 immediately. After release, read 0x1FEC00 -> next cycle dOut=0x00, hit=1.
- Basic period: write 0x1FEC00=0x02, write 0x1FEC01=0x01 -> irq_timer rises exactly 12 cycles after the start write. Counter read sequence across ticks is 2,1,0 then 2. Next IRQ arrives 12 cycles later.
- Ack: with irq_timer=1, write 0x1FF403=0xFF -> irq_timer=0 next cycle. Ack landing on the underflow cycle -> irq_timer remains 1.
- Stop/hold: run with reload=5, stop after 2 ticks -> counter reads 3 and no further IRQs. Restart -> counter reloads to 5.
- Reload change while running: reload=3 running, write reload=1 -> the current cycle finishes from 3. Post-underflow periods become 8 cycles.
- Illegal and mirror: re=we=1 on 0x1FEC00 -> reload unchanged, hit=0. Read at 0x1FEDF0 (even) mirrors port 0. PRESCALE=1024: reload=0 -> IRQ period 1024 cycles.
